// File: rtl/rvh_mmu_pkg.sv
// Shared types and widths for the PTW miss-status holding registers.
package rvh_mmu_pkg;

  localparam int VPN_WIDTH      = 27;
  localparam int ASID_WIDTH     = 16;
  localparam int TRANS_ID_WIDTH = 3;
  localparam int ACC_WIDTH      = 2;

  typedef enum logic [1:0] {
    MSHR_FREE = 2'd0,
    MSHR_PEND = 2'd1,
    MSHR_INFL = 2'd2,
    MSHR_KILL = 2'd3
  } mshr_state_e;

  typedef struct packed {
    mshr_state_e           state;
    logic [ASID_WIDTH-1:0] asid;
    logic [VPN_WIDTH-1:0]  vpn;
    logic [ACC_WIDTH-1:0]  acc;
  } mshr_entry_t;

  // Two misses are the same walk when both ASID and VPN agree.
  function automatic logic key_match(input logic [ASID_WIDTH-1:0] asid_a,
                                     input logic [VPN_WIDTH-1:0]  vpn_a,
                                     input logic [ASID_WIDTH-1:0] asid_b,
                                     input logic [VPN_WIDTH-1:0]  vpn_b);
    return (asid_a == asid_b) && (vpn_a == vpn_b);
  endfunction

endpackage

// File: rtl/rvh_mmu_mshr_entry.sv
// One MSHR entry: lifecycle FSM plus the registered miss payload.
module rvh_mmu_mshr_entry
  import rvh_mmu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_i,
  input  logic [ASID_WIDTH-1:0] alloc_asid_i,
  input  logic [VPN_WIDTH-1:0]  alloc_vpn_i,
  input  logic [ACC_WIDTH-1:0]  alloc_acc_i,
  input  logic                  fire_i,
  input  logic                  resp_i,
  input  logic                  flush_i,
  input  logic                  flush_asid_vld_i,
  input  logic [ASID_WIDTH-1:0] flush_asid_i,
  output mshr_entry_t           entry_o,
  output logic                  flush_hit_o
);

  mshr_entry_t entry_q;
  mshr_entry_t entry_d;

  // Only live (PEND/INFL) entries react to a flush; KILL is already dead.
  always_comb begin
    flush_hit_o = flush_i &&
                  ((entry_q.state == MSHR_PEND) || (entry_q.state == MSHR_INFL)) &&
                  (!flush_asid_vld_i || (entry_q.asid == flush_asid_i));
  end

  // Next-state: a response beats a flush; a walk fired during a flush is killed.
  always_comb begin
    entry_d = entry_q;
    case (entry_q.state)
      MSHR_FREE: begin
        if (alloc_i) begin
          entry_d.state = MSHR_PEND;
          entry_d.asid  = alloc_asid_i;
          entry_d.vpn   = alloc_vpn_i;
          entry_d.acc   = alloc_acc_i;
        end else begin
          entry_d.state = MSHR_FREE;
        end
      end
      MSHR_PEND: begin
        if (fire_i) begin
          entry_d.state = flush_hit_o ? MSHR_KILL : MSHR_INFL;
        end else if (flush_hit_o) begin
          entry_d.state = MSHR_FREE;
        end else begin
          entry_d.state = MSHR_PEND;
        end
      end
      MSHR_INFL: begin
        if (resp_i) begin
          entry_d.state = MSHR_FREE;
        end else if (flush_hit_o) begin
          entry_d.state = MSHR_KILL;
        end else begin
          entry_d.state = MSHR_INFL;
        end
      end
      MSHR_KILL: begin
        if (resp_i) begin
          entry_d.state = MSHR_FREE;
        end else begin
          entry_d.state = MSHR_KILL;
        end
      end
      default: entry_d.state = MSHR_FREE;
    endcase
  end

  // Entry state and payload registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q <= '{state: MSHR_FREE, asid: '0, vpn: '0, acc: '0};
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry_o = entry_q;

endmodule

// File: rtl/rvh_mmu_ptw_mshr.sv
// TLB-miss MSHR: merges duplicate misses, issues walks round-robin, broadcasts completions.
module rvh_mmu_ptw_mshr
  import rvh_mmu_pkg::*;
#(
  parameter int ALLOC_WIDTH = 2,
  parameter int ENTRY_COUNT = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [ALLOC_WIDTH-1:0]            req_vld_i,
  input  logic [ALLOC_WIDTH*ASID_WIDTH-1:0] req_asid_i,
  input  logic [ALLOC_WIDTH*VPN_WIDTH-1:0]  req_vpn_i,
  input  logic [ALLOC_WIDTH*ACC_WIDTH-1:0]  req_acc_type_i,
  output logic [ALLOC_WIDTH-1:0]            req_rdy_o,
  output logic                              ptw_req_vld_o,
  input  logic                              ptw_req_rdy_i,
  output logic [TRANS_ID_WIDTH-1:0]         ptw_req_id_o,
  output logic [ASID_WIDTH-1:0]             ptw_req_asid_o,
  output logic [VPN_WIDTH-1:0]              ptw_req_vpn_o,
  output logic [ACC_WIDTH-1:0]              ptw_req_acc_o,
  input  logic                              ptw_resp_vld_i,
  input  logic [TRANS_ID_WIDTH-1:0]         ptw_resp_id_i,
  output logic                              resp_vld_o,
  output logic [ASID_WIDTH-1:0]             resp_asid_o,
  output logic [VPN_WIDTH-1:0]              resp_vpn_o,
  input  logic                              flush_i,
  input  logic                              flush_asid_vld_i,
  input  logic [ASID_WIDTH-1:0]             flush_asid_i,
  output logic                              busy_o
);

  localparam int IDX_W = (ENTRY_COUNT > 1) ? $clog2(ENTRY_COUNT) : 1;

  mshr_entry_t                 entry_s      [ENTRY_COUNT];
  logic [ASID_WIDTH-1:0]       alloc_asid_s [ENTRY_COUNT];
  logic [VPN_WIDTH-1:0]        alloc_vpn_s  [ENTRY_COUNT];
  logic [ACC_WIDTH-1:0]        alloc_acc_s  [ENTRY_COUNT];
  logic [ENTRY_COUNT-1:0]      alloc_s, fire_s, resp_s, flush_hit_s, match_ok_s, busy_ent_s;
  logic [ALLOC_WIDTH-1:0]      req_rdy_s;
  logic                        any_pend_s, ptw_vld_s, ptw_fire_s;
  logic [IDX_W-1:0]            sel_s, resp_idx_s;
  logic                        resp_bcast_s;
  logic [IDX_W-1:0]            rr_ptr_q, rr_ptr_d, lock_idx_q, lock_idx_d;
  logic                        lock_q, lock_d;
  logic                        resp_vld_q, resp_vld_d;
  logic [ASID_WIDTH-1:0]       resp_asid_q, resp_asid_d;
  logic [VPN_WIDTH-1:0]        resp_vpn_q, resp_vpn_d;

  for (genvar e = 0; e < ENTRY_COUNT; e++) begin : g_entry
    assign resp_s[e]     = ptw_resp_vld_i && (ptw_resp_id_i == TRANS_ID_WIDTH'(e));
    assign fire_s[e]     = ptw_fire_s && (sel_s == IDX_W'(e));
    // An INFL entry completing this cycle must not absorb new misses.
    assign match_ok_s[e] = (entry_s[e].state == MSHR_PEND) ||
                           ((entry_s[e].state == MSHR_INFL) && !resp_s[e]);
    assign busy_ent_s[e] = (entry_s[e].state != MSHR_FREE);

    rvh_mmu_mshr_entry u_entry (
      .clk              (clk),
      .rst              (rst),
      .alloc_i          (alloc_s[e]),
      .alloc_asid_i     (alloc_asid_s[e]),
      .alloc_vpn_i      (alloc_vpn_s[e]),
      .alloc_acc_i      (alloc_acc_s[e]),
      .fire_i           (fire_s[e]),
      .resp_i           (resp_s[e]),
      .flush_i          (flush_i),
      .flush_asid_vld_i (flush_asid_vld_i),
      .flush_asid_i     (flush_asid_i),
      .entry_o          (entry_s[e]),
      .flush_hit_o      (flush_hit_s[e])
    );
  end

  // Prefix acceptance: merge against live entries or earlier accepted ports, else take lowest free entry.
  always_comb begin : p_accept
    logic blocked;
    logic merge;
    logic found;
    int   pick;
    req_rdy_s = '0;
    alloc_s   = '0;
    for (int e = 0; e < ENTRY_COUNT; e++) begin
      alloc_asid_s[e] = '0;
      alloc_vpn_s[e]  = '0;
      alloc_acc_s[e]  = '0;
    end
    blocked = 1'b0;
    merge   = 1'b0;
    found   = 1'b0;
    pick    = 0;
    for (int i = 0; i < ALLOC_WIDTH; i++) begin
      merge = 1'b0;
      found = 1'b0;
      pick  = 0;
      if (req_vld_i[i] && !blocked) begin
        if (flush_i) begin
          blocked = 1'b1;
        end else begin
          for (int e = 0; e < ENTRY_COUNT; e++) begin
            if (match_ok_s[e] &&
                key_match(entry_s[e].asid, entry_s[e].vpn,
                          req_asid_i[i*ASID_WIDTH +: ASID_WIDTH], req_vpn_i[i*VPN_WIDTH +: VPN_WIDTH])) begin
              merge = 1'b1;
            end
          end
          for (int j = 0; j < ALLOC_WIDTH; j++) begin
            if ((j < i) && req_rdy_s[j] &&
                key_match(req_asid_i[j*ASID_WIDTH +: ASID_WIDTH], req_vpn_i[j*VPN_WIDTH +: VPN_WIDTH],
                          req_asid_i[i*ASID_WIDTH +: ASID_WIDTH], req_vpn_i[i*VPN_WIDTH +: VPN_WIDTH])) begin
              merge = 1'b1;
            end
          end
          if (merge) begin
            req_rdy_s[i] = 1'b1;
          end else begin
            for (int e = ENTRY_COUNT - 1; e >= 0; e--) begin
              if ((entry_s[e].state == MSHR_FREE) && !alloc_s[e]) begin
                found = 1'b1;
                pick  = e;
              end
            end
            if (found) begin
              req_rdy_s[i]       = 1'b1;
              alloc_s[pick]      = 1'b1;
              alloc_asid_s[pick] = req_asid_i[i*ASID_WIDTH +: ASID_WIDTH];
              alloc_vpn_s[pick]  = req_vpn_i[i*VPN_WIDTH +: VPN_WIDTH];
              alloc_acc_s[pick]  = req_acc_type_i[i*ACC_WIDTH +: ACC_WIDTH];
            end else begin
              blocked = 1'b1;
            end
          end
        end
      end else begin
        blocked = blocked;
      end
    end
  end

  // Round-robin pick from rr_ptr; a stalled pick stays locked so the payload holds.
  always_comb begin : p_pick
    int idx;
    any_pend_s = 1'b0;
    sel_s      = '0;
    idx        = 0;
    for (int k = 0; k < ENTRY_COUNT; k++) begin
      idx = (int'(rr_ptr_q) + k) % ENTRY_COUNT;
      if (!any_pend_s && (entry_s[idx].state == MSHR_PEND)) begin
        any_pend_s = 1'b1;
        sel_s      = IDX_W'(idx);
      end
    end
    if (lock_q && (entry_s[lock_idx_q].state == MSHR_PEND)) begin
      sel_s = lock_idx_q;
    end else begin
      sel_s = sel_s;
    end
    ptw_vld_s  = any_pend_s && !flush_hit_s[sel_s];
    ptw_fire_s = ptw_vld_s && ptw_req_rdy_i;
    rr_ptr_d   = ptw_fire_s ? IDX_W'((int'(sel_s) + 1) % ENTRY_COUNT) : rr_ptr_q;
    lock_d     = ptw_vld_s && !ptw_req_rdy_i;
    lock_idx_d = sel_s;
  end

  // Picker pointer and stall lock registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  // Only a completing INFL walk is broadcast; KILL, FREE and PEND ids are dropped.
  always_comb begin
    resp_idx_s   = IDX_W'(ptw_resp_id_i);
    resp_bcast_s = ptw_resp_vld_i && (int'(ptw_resp_id_i) < ENTRY_COUNT) &&
                   (entry_s[resp_idx_s].state == MSHR_INFL);
    if (resp_bcast_s) begin
      resp_vld_d  = 1'b1;
      resp_asid_d = entry_s[resp_idx_s].asid;
      resp_vpn_d  = entry_s[resp_idx_s].vpn;
    end else begin
      resp_vld_d  = 1'b0;
      resp_asid_d = resp_asid_q;
      resp_vpn_d  = resp_vpn_q;
    end
  end

  // One-cycle completion broadcast register.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_vld_q  <= 1'b0;
      resp_asid_q <= '0;
      resp_vpn_q  <= '0;
    end else begin
      resp_vld_q  <= resp_vld_d;
      resp_asid_q <= resp_asid_d;
      resp_vpn_q  <= resp_vpn_d;
    end
  end

  assign req_rdy_o      = req_rdy_s;
  assign ptw_req_vld_o  = ptw_vld_s;
  assign ptw_req_id_o   = ptw_vld_s ? TRANS_ID_WIDTH'(sel_s) : '0;
  assign ptw_req_asid_o = ptw_vld_s ? entry_s[sel_s].asid : '0;
  assign ptw_req_vpn_o  = ptw_vld_s ? entry_s[sel_s].vpn : '0;
  assign ptw_req_acc_o  = ptw_vld_s ? entry_s[sel_s].acc : '0;
  assign resp_vld_o     = resp_vld_q;
  assign resp_asid_o    = resp_asid_q;
  assign resp_vpn_o     = resp_vpn_q;
  assign busy_o         = (|req_vld_i) || (|busy_ent_s) || resp_vld_q;

endmodule

// File: tb/tb_rvh_mmu_ptw_mshr.sv
// Directed self-checking bench for rvh_mmu_ptw_mshr.
module tb_rvh_mmu_ptw_mshr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_vld = 2'b00;
  logic [31:0] req_asid = 32'd0;
  logic [53:0] req_vpn = 54'd0;
  logic [3:0]  req_acc = 4'd0;
  logic [1:0]  req_rdy;
  logic        ptw_vld;
  logic        ptw_rdy = 1'b0;
  logic [2:0]  ptw_id;
  logic [15:0] ptw_asid;
  logic [26:0] ptw_vpn;
  logic [1:0]  ptw_acc;
  logic        presp_vld = 1'b0;
  logic [2:0]  presp_id = 3'd0;
  logic        resp_vld;
  logic [15:0] resp_asid;
  logic [26:0] resp_vpn;
  logic        flush = 1'b0;
  logic        flush_asid_vld = 1'b0;
  logic [15:0] flush_asid = 16'd0;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  rvh_mmu_ptw_mshr dut (
    .clk(clk), .rst(rst),
    .req_vld_i(req_vld), .req_asid_i(req_asid), .req_vpn_i(req_vpn), .req_acc_type_i(req_acc),
    .req_rdy_o(req_rdy),
    .ptw_req_vld_o(ptw_vld), .ptw_req_rdy_i(ptw_rdy), .ptw_req_id_o(ptw_id),
    .ptw_req_asid_o(ptw_asid), .ptw_req_vpn_o(ptw_vpn), .ptw_req_acc_o(ptw_acc),
    .ptw_resp_vld_i(presp_vld), .ptw_resp_id_i(presp_id),
    .resp_vld_o(resp_vld), .resp_asid_o(resp_asid), .resp_vpn_o(resp_vpn),
    .flush_i(flush), .flush_asid_vld_i(flush_asid_vld), .flush_asid_i(flush_asid),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    req_vld = 2'b00; req_asid = 32'd0; req_vpn = 54'd0; req_acc = 4'd0;
    presp_vld = 1'b0; presp_id = 3'd0;
    flush = 1'b0; flush_asid_vld = 1'b0; flush_asid = 16'd0;
  endtask

  task automatic put(input int p, input logic [15:0] a, input logic [26:0] v);
    req_vld[p] = 1'b1;
    req_asid[p*16 +: 16] = a;
    req_vpn[p*27 +: 27] = v;
    req_acc[p*2 +: 2] = 2'd1;
  endtask

  task automatic do_reset();
    clr();
    ptw_rdy = 1'b0;
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++; if (resp_vld !== 1'b0) begin n_fail++; $display("FAIL rst_resp_vld got=%0b exp=0", resp_vld); end
    n_checks++; if (ptw_vld !== 1'b0) begin n_fail++; $display("FAIL rst_ptw_vld got=%0b exp=0", ptw_vld); end
    n_checks++; if (ptw_vpn !== 27'd0 || ptw_id !== 3'd0) begin n_fail++; $display("FAIL rst_ptw_payload got id=%0d vpn=%h exp 0/0", ptw_id, ptw_vpn); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    n_checks++; if (resp_vpn !== 27'd0) begin n_fail++; $display("FAIL rst_resp_vpn got=%h exp=0", resp_vpn); end
  endtask

  task automatic test_single();
    do_reset();
    ptw_rdy = 1'b1;
    put(0, 16'd5, 27'h123);
    #1;
    n_checks++; if (req_rdy !== 2'b01) begin n_fail++; $display("FAIL single_rdy got=%b exp=01", req_rdy); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got=%0b exp=1", busy); end
    cyc(); clr(); #1;
    n_checks++; if (ptw_vld !== 1'b1 || ptw_id !== 3'd0 || ptw_vpn !== 27'h123 || ptw_asid !== 16'd5)
      begin n_fail++; $display("FAIL single_issue got vld=%0b id=%0d vpn=%h asid=%0d exp 1/0/123/5", ptw_vld, ptw_id, ptw_vpn, ptw_asid); end
    cyc(); #1;
    n_checks++; if (ptw_vld !== 1'b0) begin n_fail++; $display("FAIL single_after_fire got=%0b exp=0", ptw_vld); end
    presp_vld = 1'b1; presp_id = 3'd0;
    #1;
    n_checks++; if (resp_vld !== 1'b0) begin n_fail++; $display("FAIL single_resp_early got=%0b exp=0", resp_vld); end
    cyc(); clr(); #1;
    n_checks++; if (resp_vld !== 1'b1 || resp_vpn !== 27'h123 || resp_asid !== 16'd5)
      begin n_fail++; $display("FAIL single_resp got vld=%0b vpn=%h asid=%0d exp 1/123/5", resp_vld, resp_vpn, resp_asid); end
    cyc(); #1;
    n_checks++; if (resp_vld !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_idle got resp=%0b busy=%0b exp 0/0", resp_vld, busy); end
  endtask

  task automatic test_merge();
    do_reset();
    ptw_rdy = 1'b1;
    put(0, 16'd5, 27'h123); put(1, 16'd5, 27'h123);
    #1;
    n_checks++; if (req_rdy !== 2'b11) begin n_fail++; $display("FAIL merge_same_cycle got=%b exp=11", req_rdy); end
    cyc(); clr(); #1;
    n_checks++; if (ptw_vld !== 1'b1 || ptw_id !== 3'd0) begin n_fail++; $display("FAIL merge_issue got vld=%0b id=%0d exp 1/0", ptw_vld, ptw_id); end
    cyc();
    put(0, 16'd5, 27'h123);
    #1;
    n_checks++; if (req_rdy !== 2'b01) begin n_fail++; $display("FAIL merge_infl_rdy got=%b exp=01", req_rdy); end
    cyc(); clr(); #1;
    n_checks++; if (ptw_vld !== 1'b0) begin n_fail++; $display("FAIL merge_single_walk got=%0b exp=0", ptw_vld); end
    // Same key arriving while its walk completes is a fresh miss.
    presp_vld = 1'b1; presp_id = 3'd0;
    put(0, 16'd5, 27'h123);
    #1;
    n_checks++; if (req_rdy !== 2'b01) begin n_fail++; $display("FAIL merge_resp_excl_rdy got=%b exp=01", req_rdy); end
    cyc(); clr(); #1;
    n_checks++; if (ptw_vld !== 1'b1 || ptw_id !== 3'd1) begin n_fail++; $display("FAIL merge_resp_excl_alloc got vld=%0b id=%0d exp 1/1", ptw_vld, ptw_id); end
    n_checks++; if (resp_vld !== 1'b1) begin n_fail++; $display("FAIL merge_resp got=%0b exp=1", resp_vld); end
  endtask

  task automatic test_full();
    int          got_id [6];
    logic [26:0] got_vpn [6];
    int          exp_id [6];
    logic [26:0] exp_vpn [6];
    int          nf;
    exp_id  = '{3, 4, 5, 6, 7, 2};
    exp_vpn = '{27'h203, 27'h204, 27'h205, 27'h206, 27'h207, 27'h300};
    nf = 0;
    for (int k = 0; k < 6; k++) begin got_id[k] = -1; got_vpn[k] = 27'd0; end
    do_reset();
    ptw_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      put(0, 16'd4, 27'h200 + 27'(2*k)); put(1, 16'd4, 27'h201 + 27'(2*k));
      #1;
      n_checks++; if (req_rdy !== 2'b11) begin n_fail++; $display("FAIL full_fill%0d got=%b exp=11", k, req_rdy); end
      cyc(); clr(); #1;
      n_checks++; if (ptw_vld !== 1'b1 || ptw_id !== 3'd0 || ptw_vpn !== 27'h200)
        begin n_fail++; $display("FAIL full_stall_hold%0d got vld=%0b id=%0d vpn=%h exp 1/0/200", k, ptw_vld, ptw_id, ptw_vpn); end
    end
    put(0, 16'd4, 27'h300); put(1, 16'd4, 27'h203);
    #1;
    n_checks++; if (req_rdy !== 2'b00) begin n_fail++; $display("FAIL full_prefix got=%b exp=00", req_rdy); end
    clr(); put(1, 16'd4, 27'h203);
    #1;
    n_checks++; if (req_rdy !== 2'b10) begin n_fail++; $display("FAIL full_skip_idle_port got=%b exp=10", req_rdy); end
    clr(); put(0, 16'd4, 27'h203);
    #1;
    n_checks++; if (req_rdy !== 2'b01) begin n_fail++; $display("FAIL full_dup_merge got=%b exp=01", req_rdy); end
    clr();
    ptw_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (ptw_id !== 3'(k)) begin n_fail++; $display("FAIL full_fire%0d got=%0d exp=%0d", k, ptw_id, k); end
      cyc();
    end
    ptw_rdy = 1'b0;
    presp_vld = 1'b1; presp_id = 3'd2;
    put(0, 16'd4, 27'h300);
    #1;
    n_checks++; if (req_rdy !== 2'b00) begin n_fail++; $display("FAIL full_freed_same_cycle got=%b exp=00", req_rdy); end
    cyc(); clr();
    put(0, 16'd4, 27'h300);
    #1;
    n_checks++; if (req_rdy !== 2'b01) begin n_fail++; $display("FAIL full_realloc got=%b exp=01", req_rdy); end
    n_checks++; if (resp_vld !== 1'b1 || resp_vpn !== 27'h202) begin n_fail++; $display("FAIL full_resp got vld=%0b vpn=%h exp 1/202", resp_vld, resp_vpn); end
    cyc(); clr();
    ptw_rdy = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (ptw_vld && nf < 6) begin got_id[nf] = int'(ptw_id); got_vpn[nf] = ptw_vpn; nf++; end
      cyc();
    end
    n_checks++; if (nf != 6) begin n_fail++; $display("FAIL full_drain_count got=%0d exp=6", nf); end
    for (int k = 0; k < 6; k++) begin
      n_checks++; if (got_id[k] != exp_id[k] || got_vpn[k] !== exp_vpn[k])
        begin n_fail++; $display("FAIL full_drain%0d got id=%0d vpn=%h exp %0d/%h", k, got_id[k], got_vpn[k], exp_id[k], exp_vpn[k]); end
    end
  endtask

  task automatic test_flush();
    do_reset();
    ptw_rdy = 1'b0;
    put(0, 16'd1, 27'h10); put(1, 16'd1, 27'h11);
    cyc(); clr();
    put(0, 16'd2, 27'h20);
    cyc(); clr();
    ptw_rdy = 1'b1;
    #1;
    n_checks++; if (ptw_id !== 3'd0) begin n_fail++; $display("FAIL flush_first_fire got=%0d exp=0", ptw_id); end
    cyc();
    ptw_rdy = 1'b0;
    flush = 1'b1; flush_asid_vld = 1'b1; flush_asid = 16'd1;
    put(0, 16'd3, 27'h30);
    #1;
    n_checks++; if (ptw_vld !== 1'b0) begin n_fail++; $display("FAIL flush_drop_vld got=%0b exp=0", ptw_vld); end
    n_checks++; if (req_rdy !== 2'b00) begin n_fail++; $display("FAIL flush_rdy got=%b exp=00", req_rdy); end
    cyc(); clr(); #1;
    n_checks++; if (ptw_vld !== 1'b1 || ptw_id !== 3'd2 || ptw_vpn !== 27'h20)
      begin n_fail++; $display("FAIL flush_keep_other got vld=%0b id=%0d vpn=%h exp 1/2/20", ptw_vld, ptw_id, ptw_vpn); end
    put(0, 16'd1, 27'h10);
    #1;
    n_checks++; if (req_rdy !== 2'b01) begin n_fail++; $display("FAIL flush_kill_no_merge got=%b exp=01", req_rdy); end
    cyc(); clr();
    presp_vld = 1'b1; presp_id = 3'd0;
    cyc(); clr(); #1;
    n_checks++; if (resp_vld !== 1'b0) begin n_fail++; $display("FAIL flush_kill_resp got=%0b exp=0", resp_vld); end
    ptw_rdy = 1'b1;
    #1;
    n_checks++; if (ptw_id !== 3'd2) begin n_fail++; $display("FAIL flush_issue_a got=%0d exp=2", ptw_id); end
    cyc(); #1;
    n_checks++; if (ptw_vld !== 1'b1 || ptw_id !== 3'd1 || ptw_vpn !== 27'h10 || ptw_asid !== 16'd1)
      begin n_fail++; $display("FAIL flush_issue_b got vld=%0b id=%0d vpn=%h asid=%0d exp 1/1/10/1", ptw_vld, ptw_id, ptw_vpn, ptw_asid); end
    cyc(); ptw_rdy = 1'b0; #1;
    n_checks++; if (ptw_vld !== 1'b0) begin n_fail++; $display("FAIL flush_no_reissue got=%0b exp=0", ptw_vld); end
  endtask

  task automatic test_rr_stall();
    logic [2:0]  exp_id [3];
    logic [26:0] exp_vpn [3];
    exp_id  = '{3'd1, 3'd2, 3'd0};
    exp_vpn = '{27'h61, 27'h62, 27'h60};
    do_reset();
    ptw_rdy = 1'b1;
    put(0, 16'd7, 27'h50);
    cyc(); clr();
    cyc();
    ptw_rdy = 1'b0;
    presp_vld = 1'b1; presp_id = 3'd0;
    cyc(); clr();
    put(0, 16'd7, 27'h60); put(1, 16'd7, 27'h61);
    cyc(); clr();
    put(0, 16'd7, 27'h62);
    cyc(); clr();
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (ptw_vld !== 1'b1 || ptw_id !== 3'd1 || ptw_vpn !== 27'h61)
        begin n_fail++; $display("FAIL rr_stall_hold%0d got vld=%0b id=%0d vpn=%h exp 1/1/61", k, ptw_vld, ptw_id, ptw_vpn); end
      cyc();
    end
    ptw_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (ptw_vld !== 1'b1 || ptw_id !== exp_id[k] || ptw_vpn !== exp_vpn[k])
        begin n_fail++; $display("FAIL rr_order%0d got vld=%0b id=%0d vpn=%h exp 1/%0d/%h", k, ptw_vld, ptw_id, ptw_vpn, exp_id[k], exp_vpn[k]); end
      cyc();
    end
    #1;
    n_checks++; if (ptw_vld !== 1'b0) begin n_fail++; $display("FAIL rr_done got=%0b exp=0", ptw_vld); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ptw_rdy = 1'b1;
    put(0, 16'd9, 27'h70); put(1, 16'd9, 27'h71);
    cyc(); clr();
    put(0, 16'd9, 27'h72); put(1, 16'd9, 27'h73);
    cyc(); clr();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || ptw_vld !== 1'b0 || resp_vld !== 1'b0)
      begin n_fail++; $display("FAIL midrst_idle got busy=%0b vld=%0b resp=%0b exp 0/0/0", busy, ptw_vld, resp_vld); end
    presp_vld = 1'b1; presp_id = 3'd1;
    cyc(); clr(); #1;
    n_checks++; if (resp_vld !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_late_resp got resp=%0b busy=%0b exp 0/0", resp_vld, busy); end
    put(0, 16'd9, 27'h74);
    cyc(); clr(); #1;
    n_checks++; if (ptw_vld !== 1'b1 || ptw_id !== 3'd0 || ptw_vpn !== 27'h74)
      begin n_fail++; $display("FAIL midrst_realloc got vld=%0b id=%0d vpn=%h exp 1/0/74", ptw_vld, ptw_id, ptw_vpn); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_merge();
    test_full();
    test_flush();
    test_rr_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
